// File: rtl/config_loader.sv
// config_loader
//
// Front end of the fabric configuration path. A byte-wide bitstream arrives
// over a valid/ready handshake. The first byte must equal SYNC_BYTE. The
// payload bytes that follow are serialized LSB-first onto the configuration
// shift chain. The chain holds every logic tile's LUT/FF-select memory and
// every switch box's one-hot select. After the last chain bit has been
// shifted, cfg_latch pulses for one cycle so that the fabric adopts the new
// configuration atomically.
//
// Optional build macro: CFG_CRC_EN
//   Defined   : after the payload, one more byte is accepted and compared
//               against a CRC-8 (poly 0x07, init 0x00, MSB-first) computed
//               over all payload bytes as received. On a mismatch the load
//               aborts without latching.
//   Undefined : no CRC logic. The load latches directly after the last shift.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous active-high reset
//   start      begin a load (honoured in IDLE, DONE, ERROR only)
//   in_data    bitstream byte
//   in_valid   in_data valid
//   in_ready   loader accepts in_data this cycle (registered)
//   cfg_sdata  serial configuration bit, valid while cfg_shift is high
//   cfg_shift  chain shift enable
//   cfg_latch  one-cycle pulse that commits the chain contents
//   busy       load in progress
//   done       last load completed (sticky until next start)
//   error      last load aborted (sticky until next start)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start after reset
// SYNC   | waiting for the sync byte
// LOAD   | accepting payload bytes and shifting them onto the chain
// CRC    | waiting for the check byte (CFG_CRC_EN builds only)
// LATCH  | cfg_latch asserted for one cycle
// DONE   | load complete; waiting for start
// ERROR  | load aborted; waiting for start

module config_loader #(
    parameter int         NUM_TILES    = 22,
    parameter int         TILE_BITS    = 33,
    parameter int         NUM_SWITCHES = 13,
    parameter int         SWITCH_BITS  = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cfg_sdata,
    output logic       cfg_shift,
    output logic       cfg_latch,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int TOTAL_BITS = NUM_TILES * TILE_BITS + NUM_SWITCHES * SWITCH_BITS;
    localparam int NUM_BYTES  = (TOTAL_BITS + 7) / 8;
    localparam int LAST_BITS  = TOTAL_BITS - 8 * (NUM_BYTES - 1);
    localparam int BYTE_W     = $clog2(NUM_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LOAD,
`ifdef CFG_CRC_EN
        S_CRC,
`endif
        S_LATCH,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    logic [2:0]        bit_cnt;   // bits still to show after the current one
    logic [BYTE_W-1:0] byte_cnt;  // payload bytes not yet accepted
    logic [6:0]        shreg;     // remaining bits of the byte being shifted

`ifdef CFG_CRC_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc8_next(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            cfg_sdata <= 1'b0;
            cfg_shift <= 1'b0;
            cfg_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
            shreg     <= 7'd0;
`ifdef CFG_CRC_EN
            crc       <= 8'h00;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_SYNC;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
`ifdef CFG_CRC_EN
                        crc      <= 8'h00;
`endif
                    end
                end

                S_SYNC: begin
                    if (in_valid && in_ready) begin
                        if (in_data == SYNC_BYTE) begin
                            // in_ready stays high: the shifter is empty
                            state    <= S_LOAD;
                            byte_cnt <= BYTE_W'(NUM_BYTES);
                        end else begin
                            state    <= S_ERROR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (cfg_shift) begin
                        if (bit_cnt != 3'd0) begin
                            cfg_sdata <= shreg[0];
                            shreg     <= {1'b0, shreg[6:1]};
                            bit_cnt   <= bit_cnt - 3'd1;
                        end else begin
                            // last bit of this byte has just been shown
                            cfg_shift <= 1'b0;
                            cfg_sdata <= 1'b0;
                            if (byte_cnt == '0) begin
`ifdef CFG_CRC_EN
                                state    <= S_CRC;
                                in_ready <= 1'b1;
`else
                                state     <= S_LATCH;
                                cfg_latch <= 1'b1;
`endif
                            end else begin
                                in_ready <= 1'b1;
                            end
                        end
                    end else if (in_valid && in_ready) begin
                        // bit 0 goes out on the very next cycle
                        in_ready  <= 1'b0;
                        cfg_shift <= 1'b1;
                        cfg_sdata <= in_data[0];
                        shreg     <= in_data[7:1];
                        byte_cnt  <= byte_cnt - BYTE_W'(1);
                        // the final byte carries only LAST_BITS chain bits; its pad is dropped
                        bit_cnt   <= (byte_cnt == BYTE_W'(1)) ? 3'(LAST_BITS - 1) : 3'd7;
`ifdef CFG_CRC_EN
                        crc       <= crc8_next(crc, in_data);
`endif
                    end
                end

`ifdef CFG_CRC_EN
                S_CRC: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (in_data == crc) begin
                            state     <= S_LATCH;
                            cfg_latch <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
`endif

                S_LATCH: begin
                    state     <= S_DONE;
                    cfg_latch <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
